// File: rtl/control_sequencer.sv
// Control-unit state register and next-state selector for the microprogrammed core.
// The current state addresses the control ROM; the ROM's ns_sel field picks where to go next.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   state_number_i decoded entry state from the instruction encoder
//   ns_sel_i       next-state select code from the control ROM
//   cr_addr_i      branch-target field from the control ROM
//   cond_i         condition-tester result (1 = pass)
//   moc_i          memory operation complete
//   stall_i        freeze the sequencer
//   state_o        current control state (registered)
//   waiting_o      combinational: waiting on moc this cycle
//   illegal_sel_o  one-cycle registered pulse after a reserved ns_sel
//   mem_fault_o    sticky registered memory-timeout flag
module control_sequencer #(
  parameter int unsigned        STATE_W     = 10,
  parameter logic [STATE_W-1:0] RESET_STATE = STATE_W'(0),
  parameter logic [STATE_W-1:0] FETCH_STATE = STATE_W'(1),
  parameter logic [STATE_W-1:0] FAULT_STATE = STATE_W'(1023),
  parameter int unsigned        MOC_TIMEOUT = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [STATE_W-1:0] state_number_i,
  input  logic [2:0]         ns_sel_i,
  input  logic [STATE_W-1:0] cr_addr_i,
  input  logic               cond_i,
  input  logic               moc_i,
  input  logic               stall_i,
  output logic [STATE_W-1:0] state_o,
  output logic               waiting_o,
  output logic               illegal_sel_o,
  output logic               mem_fault_o
);

  typedef enum logic [2:0] {
    SelDecode  = 3'd0,
    SelInc     = 3'd1,
    SelJump    = 3'd2,
    SelFetch   = 3'd3,
    SelWait    = 3'd4,
    SelCjump   = 3'd5,
    SelCdecode = 3'd6,
    SelRsvd    = 3'd7
  } ns_sel_e;

  // Last wait count before the timeout fires; MOC_TIMEOUT is limited to 2..255.
  localparam logic [7:0] WaitLast = 8'(MOC_TIMEOUT - 1);

  ns_sel_e            sel;
  logic [STATE_W-1:0] state_q, state_d, state_inc;
  logic [7:0]         wait_cnt_q, wait_cnt_d;
  logic               illegal_sel_q, illegal_sel_d;
  logic               mem_fault_q, mem_fault_d;

  assign sel       = ns_sel_e'(ns_sel_i);
  assign state_inc = state_q + STATE_W'(1);  // wraps silently at the top

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_fault_d   = mem_fault_q;
    illegal_sel_d = 1'b0;
    if (!stall_i) begin
      wait_cnt_d = '0;
      unique case (sel)
        SelDecode:  state_d = state_number_i;
        SelInc:     state_d = state_inc;
        SelJump:    state_d = cr_addr_i;
        SelFetch:   state_d = FETCH_STATE;
        SelWait: begin
          // moc arriving on the deadline cycle still completes normally.
          if (moc_i) begin
            state_d = state_inc;
          end else if (wait_cnt_q == WaitLast) begin
            state_d     = FAULT_STATE;
            mem_fault_d = 1'b1;
          end else begin
            state_d    = state_q;
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
        SelCjump:   state_d = cond_i ? cr_addr_i : state_inc;
        // cond=0 skips the instruction by returning straight to fetch.
        SelCdecode: state_d = cond_i ? state_number_i : FETCH_STATE;
        SelRsvd: begin
          state_d       = FETCH_STATE;
          illegal_sel_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= RESET_STATE;
      wait_cnt_q    <= '0;
      illegal_sel_q <= 1'b0;
      mem_fault_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      illegal_sel_q <= illegal_sel_d;
      mem_fault_q   <= mem_fault_d;
    end
  end

  assign state_o       = state_q;
  assign illegal_sel_o = illegal_sel_q;
  assign mem_fault_o   = mem_fault_q;
  assign waiting_o     = (sel == SelWait) && !moc_i && !stall_i;

endmodule
